pio_input_edge_irq: RTL and testbench
=====================================

Name: pio_input_edge_irq

Overview:
- Parametrised Avalon-MM slave input port for switches and pushbuttons on the Nios system bus.
- Brings external pins in through a synchroniser, optional per-bit debounce and edge detection.
- Keeps per-bit sticky edge-capture and interrupt-mask registers, and raises one IRQ in level or edge mode.
- Successor to the fixed-width level-only input PIO, for debounced keys and edge-triggered password entry.

Parameters:
WIDTH, 18, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flops per bit (2..4)
DEBOUNCE_CYCLES, 0, clocks a changed level must stay stable before acceptance; 0 = no debounce
EDGE_TYPE, 0, edges captured: 0 rising, 1 falling, 2 any
IRQ_MODE, 0, 0 = level (irq from data & mask), 1 = edge (irq from edgecapture & mask)

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
address  in  2  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  asynchronous external inputs
readdata  out  32  registered read data
irq  out  1  interrupt request

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (on the clk edge with reset=1) clears all of these to 0: sync flops, db, db_prev, debounce counters, irq_mask, edgecapture, readdata, warm-up counter, armed.
- Register map (bits above WIDTH read 0, writes ignore them):
  - 0 = db (read-only)
  - 1 = reads 0
  - 2 = irq_mask (R/W)
  - 3 = edgecapture (read; write-1-to-clear per bit)
- Write occurs when chipselect=1 and write_n=0; write to address 0 or 1 is ignored.
- Read path: readdata <= mux(address) on every clk edge, independent of chipselect. Latency is 1 clock. Reads have no side effects.
- Synchroniser: SYNC_STAGES-deep shift register per bit; sync_out is the last stage.
- Debounce, per bit:
  - If DEBOUNCE_CYCLES=0: db <= sync_out every clock.
  - Else, if sync_out==db: cnt <= 0.
  - Else, if cnt==DEBOUNCE_CYCLES-1: db <= sync_out and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES leaves db unchanged.
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1.
- Pin-to-db latency for a stable change: SYNC_STAGES + max(DEBOUNCE_CYCLES,1) clocks.
- Edge detect: db_prev <= db every clock.
  - rise = db & ~db_prev
  - fall = ~db & db_prev
  - edge is selected by EDGE_TYPE.
- Warm-up: after reset, a counter runs SYNC_STAGES + max(DEBOUNCE_CYCLES,1) + 1 clocks, then sets armed=1.
  - While armed=0, edges are not captured. This prevents false edges from inputs already high at reset.
- edgecapture[i]:
  - Set when armed and edge[i].
  - Cleared when a write to address 3 has writedata[i]=1.
  - Set and clear in the same clock: set wins (bit stays 1).
- irq is combinational from registers only:
  - IRQ_MODE 0: irq = |(db & irq_mask)
  - IRQ_MODE 1: irq = |(edgecapture & irq_mask)
- Writing irq_mask takes effect on irq the clock after the write.
- Reset asserted mid-debounce or mid-warm-up aborts it; the sequence restarts from zero.

Test Plan:
1. WIDTH=18, DEBOUNCE_CYCLES=0, after warm-up: in_port=0x2A5A5. Read address 0 at least 3 clocks later -> readdata=0x0002A5A5. Read address 1 -> 0.
2. DEBOUNCE_CYCLES=4, bit 0 raised for 3 clocks then dropped -> db bit 0 stays 0, edgecapture=0. Bit 0 held high -> db bit 0 =1 exactly 2+4 clocks after the change; edgecapture bit 0 =1 one clock later.
3. IRQ_MODE=1, EDGE_TYPE=0, irq_mask=0x00001: pulse bit 0 -> irq=1. Write 0x1 to address 3 -> edgecapture=0 and irq=0 next clock. Repeat with the clear landing on the same clock as a new rising edge -> bit stays 1, irq stays 1.
4. EDGE_TYPE=2: toggle bit 17 high then low, clearing in between -> capture set on both edges. EDGE_TYPE=1: rising edge -> no capture.
5. in_port=0x3FFFF held through reset release -> edgecapture remains 0 through warm-up and after it. IRQ_MODE=0 with mask 0x3FFFF -> irq=1 once db is valid.
6. Reset asserted for 1 clock mid-debounce with edgecapture=0x00010 -> all registers 0, readdata=0. Write 0xFFFFFFFF to address 2 -> readback 0x0003FFFF.

Source files
------------

// File: rtl/pio_input_edge_irq.sv
// pio_input_edge_irq: Avalon-MM slave input port for switches and pushbuttons.
// External pins pass through a synchroniser, optional per-bit debounce and an
// edge detector. Sticky per-bit edge-capture and interrupt-mask registers drive
// a single IRQ in level or edge mode.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   address    word address (0 data, 1 reads 0, 2 irq_mask, 3 edgecapture)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (bits at or above WIDTH ignored)
//   in_port    asynchronous external inputs
//   readdata   registered read data, one clock after address
//   irq        interrupt request, combinational from registers only
module pio_input_edge_irq #(
    parameter int unsigned WIDTH           = 18,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned IRQ_MODE        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned DB_EFF   = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CNT_LAST = (DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1;
    localparam int unsigned WARM_LEN = SYNC_STAGES + DB_EFF + 1;
    localparam int unsigned WARM_W   = $clog2(WARM_LEN);

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  sync_out;
    logic [WIDTH-1:0]  db_q, db_d;
    logic [WIDTH-1:0]  db_prev_q;
    logic [CNT_W-1:0]  cnt_q [WIDTH];
    logic [CNT_W-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  ecap_q, ecap_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              armed_q, armed_d;

    logic [WIDTH-1:0]  rise, fall, edge_sel;
    logic              wr_en;
    logic              unused_wdata;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = db_q & ~db_prev_q;
    assign fall     = ~db_q & db_prev_q;
    assign edge_sel = (EDGE_TYPE == 0) ? rise :
                      (EDGE_TYPE == 1) ? fall : (rise | fall);
    assign wr_en    = chipselect & ~write_n;

    // Upper writedata bits are don't-care when WIDTH < 32.
    assign unused_wdata = ^writedata;

    // Per-bit debounce: a changed level must persist DEBOUNCE_CYCLES clocks.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < int'(WIDTH); i++) cnt_d[i] = cnt_q[i];
        if (DEBOUNCE_CYCLES == 0) begin
            db_d = sync_out;
            for (int i = 0; i < int'(WIDTH); i++) cnt_d[i] = '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync_out[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_W'(CNT_LAST)) begin
                    db_d[i]  = sync_out[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register file, warm-up and read mux next-state.
    always_comb begin
        mask_d     = mask_q;
        ecap_d     = ecap_q;
        warm_d     = warm_q;
        armed_d    = armed_q;
        readdata_d = 32'd0;

        if (wr_en && (address == 2'd2)) mask_d = writedata[WIDTH-1:0];

        // Clear first, then set, so a coincident edge keeps the bit.
        if (wr_en && (address == 2'd3)) ecap_d = ecap_d & ~writedata[WIDTH-1:0];
        if (armed_q) ecap_d = ecap_d | edge_sel;

        // Edges are ignored until the input pipeline has filled after reset.
        if (!armed_q) begin
            if (warm_q == WARM_W'(WARM_LEN - 1)) armed_d = 1'b1;
            else                                  warm_d  = warm_q + WARM_W'(1);
        end

        unique case (address)
            2'd0:    readdata_d = 32'(db_q);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(ecap_q);
            default: readdata_d = 32'd0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            mask_q     <= '0;
            ecap_q     <= '0;
            readdata_q <= '0;
            warm_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
            db_q       <= db_d;
            db_prev_q  <= db_q;
            mask_q     <= mask_d;
            ecap_q     <= ecap_d;
            readdata_q <= readdata_d;
            warm_q     <= warm_d;
            armed_q    <= armed_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = (IRQ_MODE == 1) ? |(ecap_q & mask_q) : |(db_q & mask_q);

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Scoreboard bench for pio_input_edge_irq. Three instances share one bus and
// in_port: A (no debounce, rising, edge irq), B (debounce 4, any edge, level
// irq), C (no debounce, falling, level irq). Expectations pushed in a driver
// window are compared by the monitor after the next rising edge.
module tb_pio_input_edge_irq;

    localparam int unsigned W = 18;

    typedef struct {
        int          dut;
        int          kind;   // 0 readdata, 1 irq
        logic [31:0] val;
        string       name;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [W-1:0] in_port;
    logic [31:0]  rd_a, rd_b, rd_c;
    logic         irq_a, irq_b, irq_c;

    exp_t        sb[$];
    int          obs = 0;
    int          obs_q = 0;
    int          errors = 0;
    int          checks = 0;
    logic        fin_req = 1'b0;
    logic        fin_done = 1'b0;
    exp_t        mon_e;
    logic [31:0] mon_got;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pio_input_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                         .EDGE_TYPE(0), .IRQ_MODE(1)) u_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a));

    pio_input_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                         .EDGE_TYPE(2), .IRQ_MODE(0)) u_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_b), .irq(irq_b));

    pio_input_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0),
                         .EDGE_TYPE(1), .IRQ_MODE(0)) u_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_c), .irq(irq_c));

    // Number of expectations due after this rising edge.
    always @(posedge clk) obs_q <= obs;

    // Monitor: pop and compare the expectations due after the last edge.
    always @(negedge clk) begin
        for (int k = 0; k < obs_q; k++) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_underflow: no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                case (mon_e.dut)
                    0:       mon_got = (mon_e.kind == 1) ? {31'd0, irq_a} : rd_a;
                    1:       mon_got = (mon_e.kind == 1) ? {31'd0, irq_b} : rd_b;
                    default: mon_got = (mon_e.kind == 1) ? {31'd0, irq_c} : rd_c;
                endcase
                if (mon_got !== mon_e.val) begin
                    errors = errors + 1;
                    $display("FAIL %s dut=%0d got=%h want=%h t=%0t",
                             mon_e.name, mon_e.dut, mon_got, mon_e.val, $time);
                end
            end
        end
        if (fin_req && !fin_done) begin
            checks = checks + 1;
            if (sb.size() != 0) begin
                errors = errors + 1;
                $display("FAIL sb_leftover got=%0d want=0", sb.size());
            end
            fin_done = 1'b1;
        end
    end

    task automatic cyc();
        @(negedge clk);
        obs        = 0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        address    = 2'd0;
    endtask

    task automatic cycn(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
    endtask

    task automatic push(input int dut, input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.dut  = dut;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
        obs = obs + 1;
    endtask

    task automatic chk_rd(input int dut, input logic [31:0] v, input string nm);
        push(dut, 0, v, nm);
    endtask

    task automatic chk_irq(input int dut, input logic v, input string nm);
        push(dut, 1, 32'(v), nm);
    endtask

    task automatic chk_rd3(input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vc, input string nm);
        push(0, 0, va, nm);
        push(1, 0, vb, nm);
        push(2, 0, vc, nm);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_port    = 18'h3FFFF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        address    = 2'd0;

        // Reset state with all inputs high.
        cyc();
        rd(2'd0); chk_rd3(0, 0, 0, "reset_rd");
        cyc();
        reset = 1'b0;
        wr(2'd2, 32'h0003FFFF);

        // Inputs high through reset release: no capture during or after warm-up.
        for (int k = 1; k <= 9; k++) begin
            cyc();
            rd(2'd3); chk_rd3(0, 0, 0, "warm_ecap");
            if (k == 1) chk_irq(2, 1'b0, "c_irq_early");
            if (k == 2) chk_irq(2, 1'b1, "c_irq_lvl");
            if (k == 4) chk_irq(1, 1'b0, "b_irq_early");
            if (k == 5) chk_irq(1, 1'b1, "b_irq_lvl");
        end

        // Data read, address 1, debounce latency, falling captures.
        cyc();
        in_port = 18'h2A5A5;
        cycn(3); rd(2'd0); chk_rd(0, 32'h0002A5A5, "a_db"); chk_rd(2, 32'h0002A5A5, "c_db");
        cyc();   rd(2'd1); chk_rd3(0, 0, 0, "addr1");
        cyc();   rd(2'd0); chk_rd(1, 32'h0003FFFF, "b_db_old");
        cyc();   rd(2'd0); chk_rd(1, 32'h0002A5A5, "b_db_new");
        cyc();   rd(2'd3); chk_rd3(0, 32'h00015A5A, 32'h00015A5A, "fall_ecap");
        cyc();   wr(2'd3, 32'hFFFFFFFF);
        cyc();   rd(2'd3); chk_rd3(0, 0, 0, "clr_all"); chk_irq(0, 1'b0, "a_irq_clr");
        cyc();
        in_port = 18'h0;
        cycn(8); wr(2'd3, 32'hFFFFFFFF);
        cyc();   rd(2'd3); chk_rd3(0, 0, 0, "clr_all2");

        // 3-clock glitch on bit 0 is filtered by the debounced instance.
        cyc();   in_port = 18'h1;
        cycn(3); in_port = 18'h0;
        cycn(3); rd(2'd0); chk_rd(1, 0, "b_glitch_db");
        cycn(2); rd(2'd3); chk_rd3(1, 0, 1, "glitch_ecap");
        cyc();   wr(2'd3, 32'h1);

        // Held change: db after 2+4 clocks, capture one clock later.
        cyc();   in_port = 18'h1;
        cycn(4); rd(2'd3); chk_rd(1, 0, "b_ecap_h4"); chk_irq(1, 1'b0, "b_db_5");
        cyc();   chk_irq(1, 1'b1, "b_db_6");
        cyc();   rd(2'd3); chk_rd(1, 0, "b_ecap_6");
        cyc();   rd(2'd3); chk_rd3(1, 1, 0, "ecap_7");
        cyc();   wr(2'd3, 32'hFFFFFFFF);
        cyc();   wr(2'd2, 32'h1);
        cyc();   in_port = 18'h0;
        cycn(8); wr(2'd3, 32'hFFFFFFFF);

        // Edge-mode irq, write-1-to-clear, and set winning over clear.
        cycn(2); in_port = 18'h1;
        cyc();   in_port = 18'h0;
        cyc();   chk_irq(0, 1'b0, "a_irq_pre");
        cyc();   chk_irq(0, 1'b1, "a_irq_edge");
        cyc();   chk_irq(0, 1'b1, "a_irq_hold");
        cyc();   wr(2'd3, 32'h1); chk_irq(0, 1'b0, "a_irq_w1c");
        cyc();   rd(2'd3); chk_rd3(0, 0, 0, "w1c_ecap");
        cyc();   in_port = 18'h1;
        cyc();   in_port = 18'h0;
        cycn(2); wr(2'd3, 32'h1); chk_irq(0, 1'b1, "a_irq_setwins");
        cyc();   rd(2'd3); chk_rd3(1, 0, 0, "setwins_ecap"); chk_irq(0, 1'b1, "a_irq_stay");
        cycn(2); wr(2'd3, 32'hFFFFFFFF);
        cyc();   rd(2'd3); chk_rd3(0, 0, 0, "clr_all3");

        // Bit 17 both edges: any-edge captures both, falling-only ignores rise.
        cyc();   in_port = 18'h20000;
        cycn(7); rd(2'd3); chk_rd3(32'h20000, 32'h20000, 0, "rise17");
        cyc();   wr(2'd3, 32'h20000);
        cyc();   rd(2'd3); chk_rd3(0, 0, 0, "clr17");
        cyc();   in_port = 18'h0;
        cycn(7); rd(2'd3); chk_rd3(0, 32'h20000, 32'h20000, "fall17");
        cyc();   wr(2'd3, 32'hFFFFFFFF);

        // Reset mid-debounce with edgecapture holding bit 4.
        cyc();   in_port = 18'h10;
        cyc();   wr(2'd2, 32'h10);
        cycn(6); rd(2'd3); chk_rd3(32'h10, 32'h10, 0, "ecap_b4");
        cyc();   in_port = 18'h0;
        cyc();   chk_irq(0, 1'b1, "a_irq_pre_rst"); chk_irq(1, 1'b1, "b_irq_pre_rst");
        cycn(2); reset = 1'b1; rd(2'd2); chk_rd3(0, 0, 0, "rst_rd");
        cyc();   reset = 1'b0; rd(2'd3); chk_rd3(0, 0, 0, "rst_ecap");
        chk_irq(0, 1'b0, "a_irq_rst"); chk_irq(1, 1'b0, "b_irq_rst");
        cyc();   rd(2'd2); chk_rd3(0, 0, 0, "rst_mask");
        cyc();   wr(2'd2, 32'hFFFFFFFF);
        cyc();   rd(2'd2); chk_rd3(32'h3FFFF, 32'h3FFFF, 32'h3FFFF, "mask_wide");

        cycn(4);
        fin_req = 1'b1;
        for (int t = 0; t < 10 && !fin_done; t++) @(negedge clk);
        if (!fin_done) begin
            $display("FAIL final_check: monitor did not respond");
            $fatal(1, "final check timeout");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
